// File: rtl/conv1_feed_ctrl.sv
// Frame feeder for the conv1 line buffer: streams a binary image from memory in
// row-major order, clears the buffer per frame and checks the window count at frame end.
module conv1_feed_ctrl #(
    parameter int unsigned WIDTH     = 28,
    parameter int unsigned HEIGHT    = 28,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DRAIN_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              hold,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_data,
    output logic              pix_valid,
    output logic              pix_data,
    output logic              buf_rst_n,
    input  logic              win_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned PIX_N = WIDTH * HEIGHT;
    localparam int unsigned WIN_N = (WIDTH - 2) * (HEIGHT - 2);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DRN_W = $clog2(DRAIN_MAX + 1);

    localparam logic [CNT_W-1:0] PIX_END  = CNT_W'(PIX_N);
    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIX_N - 1);
    localparam logic [9:0]       WIN_TGT  = 10'(WIN_N);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_rd_cnt;
    logic             r_last_rd;
    logic             r_rd_d1;
    logic             r_last_d1;
    logic             r_pix_last;
    logic [9:0]       r_win_cnt;
    logic [DRN_W-1:0] r_drain_cnt;

    logic w_issue;
    logic w_win_inc;
    logic w_win_hit;

    assign w_issue   = (r_state == S_STREAM) && !hold && (r_rd_cnt < PIX_END);
    assign w_win_inc = win_valid && ((r_state == S_STREAM) || (r_state == S_DRAIN))
                       && (r_win_cnt != '1);
    assign w_win_hit = (r_win_cnt >= WIN_TGT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            mem_rd_en   <= 1'b0;
            mem_addr    <= '0;
            pix_valid   <= 1'b0;
            pix_data    <= 1'b0;
            buf_rst_n   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            r_rd_cnt    <= '0;
            r_last_rd   <= 1'b0;
            r_rd_d1     <= 1'b0;
            r_last_d1   <= 1'b0;
            r_pix_last  <= 1'b0;
            r_win_cnt   <= '0;
            r_drain_cnt <= '0;
        end else begin
            buf_rst_n  <= 1'b1;
            done       <= 1'b0;
            // Read pipeline keeps flowing during hold so no issued read is lost.
            r_rd_d1    <= mem_rd_en;
            r_last_d1  <= r_last_rd;
            pix_valid  <= r_rd_d1;
            r_pix_last <= r_last_d1;
            if (r_rd_d1) begin
                pix_data <= mem_data;
            end
            if (w_win_inc) begin
                r_win_cnt <= r_win_cnt + 10'd1;
            end

            if (abort && (r_state != S_IDLE)) begin
                r_state    <= S_IDLE;
                busy       <= 1'b0;
                buf_rst_n  <= 1'b0;
                mem_rd_en  <= 1'b0;
                r_last_rd  <= 1'b0;
                r_rd_d1    <= 1'b0;
                r_last_d1  <= 1'b0;
                pix_valid  <= 1'b0;
                r_pix_last <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        mem_rd_en <= 1'b0;
                        r_last_rd <= 1'b0;
                        if (start && !abort) begin
                            r_state     <= S_CLEAR;
                            busy        <= 1'b1;
                            buf_rst_n   <= 1'b0;
                            err         <= 1'b0;
                            r_rd_cnt    <= '0;
                            r_win_cnt   <= '0;
                            r_drain_cnt <= '0;
                        end
                    end
                    S_CLEAR: begin
                        r_state <= S_STREAM;
                    end
                    S_STREAM: begin
                        mem_rd_en <= w_issue;
                        r_last_rd <= w_issue && (r_rd_cnt == PIX_LAST);
                        if (w_issue) begin
                            mem_addr <= r_rd_cnt[ADDR_W-1:0];
                            r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                        end
                        if (r_pix_last) begin
                            r_state     <= S_DRAIN;
                            r_drain_cnt <= '0;
                        end
                    end
                    S_DRAIN: begin
                        mem_rd_en <= 1'b0;
                        r_last_rd <= 1'b0;
                        if (w_win_hit) begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else if (r_drain_cnt == DRN_LAST) begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end else begin
                            r_drain_cnt <= r_drain_cnt + DRN_W'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv1_feed_ctrl.sv
// Directed bench for conv1_feed_ctrl with a ROM model and a 3x3 line-buffer window model.
module tb_conv1_feed_ctrl;

    localparam int WIDTH     = 28;
    localparam int HEIGHT    = 28;
    localparam int ADDR_W    = 10;
    localparam int DRAIN_MAX = 8;
    localparam int PIX       = WIDTH * HEIGHT;
    localparam int WIN       = (WIDTH - 2) * (HEIGHT - 2);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic              hold;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_data = 1'b0;
    logic              pix_valid;
    logic              pix_data;
    logic              buf_rst_n;
    logic              win_valid = 1'b0;
    logic              busy;
    logic              done;
    logic              err;

    conv1_feed_ctrl #(
        .WIDTH    (WIDTH),
        .HEIGHT   (HEIGHT),
        .ADDR_W   (ADDR_W),
        .DRAIN_MAX(DRAIN_MAX)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .hold     (hold),
        .mem_rd_en(mem_rd_en),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .pix_valid(pix_valid),
        .pix_data (pix_data),
        .buf_rst_n(buf_rst_n),
        .win_valid(win_valid),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic rom_bit(input int a);
        int v;
        v = a ^ (a >> 3) ^ (a >> 5);
        return v[0];
    endfunction

    always @(posedge clk) mem_data <= mem_rd_en ? rom_bit(int'(mem_addr)) : 1'b0;

    // Window model: one window per pixel at row >= 2 and col >= 2, capped by win_limit.
    int win_limit = 1000;
    int lb_cnt    = 0;
    int lb_win    = 0;
    always @(posedge clk) begin
        if (!buf_rst_n) begin
            lb_cnt    <= 0;
            lb_win    <= 0;
            win_valid <= 1'b0;
        end else begin
            win_valid <= 1'b0;
            if (pix_valid) begin
                lb_cnt <= lb_cnt + 1;
                if ((lb_cnt / WIDTH) >= 2 && (lb_cnt % WIDTH) >= 2 && lb_win < win_limit) begin
                    win_valid <= 1'b1;
                    lb_win    <= lb_win + 1;
                end
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_rd = 0, n_pix = 0, n_done = 0, n_win = 0, n_bufrst = 0;
    int rd_bad = 0, pix_bad = 0, rd_idx = 0, pix_idx = 0;
    int last_pix_cyc = 0, done_cyc = 0, bufrst_cyc = 0;
    always @(negedge clk) begin
        if (!buf_rst_n) begin
            rd_idx     <= 0;
            pix_idx    <= 0;
            n_bufrst   <= n_bufrst + 1;
            bufrst_cyc <= cyc;
        end else begin
            if (mem_rd_en) begin
                if (int'(mem_addr) != rd_idx) rd_bad <= rd_bad + 1;
                rd_idx <= rd_idx + 1;
            end
            if (pix_valid) begin
                if (pix_data !== rom_bit(pix_idx)) pix_bad <= pix_bad + 1;
                pix_idx      <= pix_idx + 1;
                last_pix_cyc <= cyc;
            end
        end
        if (mem_rd_en) n_rd <= n_rd + 1;
        if (pix_valid) n_pix <= n_pix + 1;
        if (win_valid) n_win <= n_win + 1;
        if (done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
        end
    end

    int b_rd, b_pix, b_done, b_win, b_bufrst, b_rdbad, b_pixbad;

    task automatic snap();
        b_rd     = n_rd;
        b_pix    = n_pix;
        b_done   = n_done;
        b_win    = n_win;
        b_bufrst = n_bufrst;
        b_rdbad  = rd_bad;
        b_pixbad = pix_bad;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string t);
        int n0;
        int k;
        n0 = n_done;
        k  = 0;
        while (n_done == n0 && k < bound) begin
            step();
            k++;
        end
        check({t, "_done_seen"}, int'(n_done != n0), 1);
    endtask

    task automatic wait_addr(input int a, input int bound, input string t);
        int k;
        k = 0;
        while (!(mem_rd_en && int'(mem_addr) == a) && k < bound) begin
            step();
            k++;
        end
        check({t, "_reach_addr"}, int'(mem_rd_en && int'(mem_addr) == a), 1);
    endtask

    task automatic frame_checks(input string t, input int win_exp);
        check({t, "_n_rd"},     n_rd - b_rd, PIX);
        check({t, "_rd_addr"},  rd_bad - b_rdbad, 0);
        check({t, "_n_pix"},    n_pix - b_pix, PIX);
        check({t, "_pix_data"}, pix_bad - b_pixbad, 0);
        check({t, "_n_win"},    n_win - b_win, win_exp);
        check({t, "_n_done"},   n_done - b_done, 1);
        check({t, "_busy"},     int'(busy), 0);
    endtask

    int d1;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        hold  = 1'b0;
        step();
        step();
        check("rst_rd_en",   int'(mem_rd_en), 0);
        check("rst_addr",    int'(mem_addr), 0);
        check("rst_pix_vld", int'(pix_valid), 0);
        check("rst_pix_dat", int'(pix_data), 0);
        check("rst_buf_rst", int'(buf_rst_n), 1);
        check("rst_busy",    int'(busy), 0);
        check("rst_done",    int'(done), 0);
        check("rst_err",     int'(err), 0);
        rst_n = 1'b1;
        step();

        // abort beats start in IDLE
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("idle_abort_start_busy", int'(busy), 0);
        check("idle_abort_start_buf",  int'(buf_rst_n), 1);

        // full frame, no hold
        snap();
        pulse_start();
        check("t1_clear_busy",  int'(busy), 1);
        check("t1_clear_buf",   int'(buf_rst_n), 0);
        step();
        check("t1_clear_1cyc",  int'(buf_rst_n), 1);
        check("t1_no_rd_yet",   int'(mem_rd_en), 0);
        step();
        check("t1_first_rd",    int'(mem_rd_en), 1);
        check("t1_first_addr",  int'(mem_addr), 0);
        wait_done(3000, "t1");
        check("t1_done_lat",    done_cyc - last_pix_cyc, 3);
        check("t1_err",         int'(err), 0);
        repeat (5) step();
        frame_checks("t1", WIN);
        check("t1_n_bufrst",    n_bufrst - b_bufrst, 1);

        // hold for 5 cycles at address 100
        snap();
        pulse_start();
        wait_addr(100, 2000, "t2");
        hold = 1'b1;
        step();
        check("t2_hold_rd_en", int'(mem_rd_en), 0);
        check("t2_hold_addr",  int'(mem_addr), 100);
        repeat (4) step();
        check("t2_hold_addr_end", int'(mem_addr), 100);
        hold = 1'b0;
        wait_done(3000, "t2");
        check("t2_err", int'(err), 0);
        repeat (5) step();
        frame_checks("t2", WIN);

        // window shortfall: drain timeout
        win_limit = 600;
        snap();
        pulse_start();
        wait_done(3000, "t3");
        check("t3_err",      int'(err), 1);
        check("t3_done_lat", done_cyc - last_pix_cyc, DRAIN_MAX + 1);
        repeat (5) step();
        frame_checks("t3", 600);
        check("t3_err_sticky", int'(err), 1);

        // next start clears err, then abort at address 400
        win_limit = 1000;
        pulse_start();
        check("t4_start_clr_err", int'(err), 0);
        wait_addr(400, 2000, "t4");
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_abort_rd_en", int'(mem_rd_en), 0);
        check("t4_abort_pixv",  int'(pix_valid), 0);
        check("t4_abort_buf",   int'(buf_rst_n), 0);
        check("t4_abort_busy",  int'(busy), 0);
        check("t4_abort_err",   int'(err), 0);
        step();
        check("t4_abort_buf_1cyc", int'(buf_rst_n), 1);
        snap();
        repeat (20) step();
        check("t4_post_pix",  n_pix - b_pix, 0);
        check("t4_post_done", n_done - b_done, 0);
        check("t4_post_rd",   n_rd - b_rd, 0);

        snap();
        pulse_start();
        step();
        step();
        check("t4b_first_rd",   int'(mem_rd_en), 1);
        check("t4b_first_addr", int'(mem_addr), 0);
        wait_done(3000, "t4b");
        repeat (5) step();
        frame_checks("t4b", WIN);

        // start held high: back-to-back frames
        snap();
        start = 1'b1;
        wait_done(3000, "t5a");
        d1 = done_cyc;
        wait_done(3000, "t5b");
        start = 1'b0;
        repeat (5) step();
        check("t5_n_done",   n_done - b_done, 2);
        check("t5_n_rd",     n_rd - b_rd, 2 * PIX);
        check("t5_rd_addr",  rd_bad - b_rdbad, 0);
        check("t5_n_pix",    n_pix - b_pix, 2 * PIX);
        check("t5_pix_data", pix_bad - b_pixbad, 0);
        check("t5_n_bufrst", n_bufrst - b_bufrst, 2);
        check("t5_restart_gap", bufrst_cyc - d1, 1);
        check("t5_busy",     int'(busy), 0);

        // reset mid-frame at address 300
        pulse_start();
        wait_addr(300, 2000, "t6");
        rst_n = 1'b0;
        #1;
        check("t6_rst_rd_en", int'(mem_rd_en), 0);
        check("t6_rst_addr",  int'(mem_addr), 0);
        check("t6_rst_pixv",  int'(pix_valid), 0);
        check("t6_rst_busy",  int'(busy), 0);
        check("t6_rst_buf",   int'(buf_rst_n), 1);
        check("t6_rst_done",  int'(done), 0);
        step();
        step();
        rst_n = 1'b1;
        snap();
        repeat (20) step();
        check("t6_post_pix",  n_pix - b_pix, 0);
        check("t6_post_done", n_done - b_done, 0);
        check("t6_post_rd",   n_rd - b_rd, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
